// File: rtl/box_inverse_filter_pkg.sv
// box_inverse_filter_pkg
//   Shared types and helpers for the moving-sum encoder/decoder pair.
//   - sum_width(N, W): width of an N-window sum of W-bit samples
//   - sample_t / sum_t: default-width sample and sum types
//   - inv_state_t: decoder window state (FILL while the window is still
//     filling from zero, RUN once N samples have been seen)
package box_inverse_filter_pkg;

  function automatic int sum_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  localparam int FILTER_SIZE_DEF = 4;
  localparam int WIDTH_DEF       = 32;
  localparam int SUM_WIDTH_DEF   = sum_width(FILTER_SIZE_DEF, WIDTH_DEF);

  typedef logic [WIDTH_DEF-1:0]     sample_t;
  typedef logic [SUM_WIDTH_DEF-1:0] sum_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } inv_state_t;

endpackage

// File: rtl/box_inverse_filter_if.sv
// box_inverse_filter_if
//   Stream bundle around the inverse box filter.
//   in_valid/in_ready/in_sum : upstream window-sum stream
//   out_valid/out_ready/out  : downstream reconstructed-sample stream
//   master modport: producer + consumer side; slave modport: the decoder.
interface box_inverse_filter_if #(
  parameter int WIDTH     = 32,
  parameter int SUM_WIDTH = 34
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SUM_WIDTH-1:0] in_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/box_inverse_filter_sample_history.sv
// box_inverse_filter_sample_history
//   Shift-register delay line holding the last DEPTH decoded samples.
//   clk    : clock
//   clr_i  : synchronous clear of every entry
//   push_i : shift in din_i at entry 0
//   din_i  : sample to push
//   tap_o  : oldest entry (pushed DEPTH pushes ago)
//   clr_i and push_i together leave {din_i, 0, ..., 0}.
module box_inverse_filter_sample_history #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] tap_o
);

  logic [DEPTH-1:0][WIDTH-1:0] hist_q, hist_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hist_d[i] = clr_i ? '0 : hist_q[i];
    end
    if (push_i) begin
      hist_d[0] = din_i;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = clr_i ? '0 : hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  assign tap_o = hist_q[DEPTH-1];

endmodule

// File: rtl/box_inverse_filter.sv
// box_inverse_filter
//   Reconstructs x[n] = S[n] - S[n-1] + x[n-N] from a stream of N-window
//   moving sums (all modulo 2^SUM_WIDTH), with a one-entry registered output.
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset
//   flush : synchronous restart of the window (history, prev sum, fill count)
//   bus   : slave side of box_inverse_filter_if (in/out valid-ready streams)
//   err   : sticky consistency error, present only when BOX_INVERSE_CHECK_EN
//           is defined
//   Optional feature macro: BOX_INVERSE_CHECK_EN
module box_inverse_filter
  import box_inverse_filter_pkg::*;
#(
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SUM_WIDTH   = sum_width(FILTER_SIZE, WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  box_inverse_filter_if.slave bus
`ifdef BOX_INVERSE_CHECK_EN
  ,
  output logic err
`endif
);

  function automatic logic [SUM_WIDTH-1:0] decode_sample(
    input logic [SUM_WIDTH-1:0] s_cur,
    input logic [SUM_WIDTH-1:0] s_prev,
    input logic [SUM_WIDTH-1:0] x_old
  );
    return s_cur - s_prev + x_old;
  endfunction

  logic                 in_ready;
  logic                 accept;
  logic [SUM_WIDTH-1:0] tap, tap_eff, prev_eff, x;
  logic [SUM_WIDTH-1:0] prev_sum_q, prev_sum_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_vld_q, out_vld_d;

  assign in_ready      = !out_vld_q || bus.out_ready;
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_vld_q;
  assign bus.out       = out_q;

  // A flush in the same cycle as an accept decodes the sample as the first
  // of a fresh window, so history and previous sum read as zero.
  assign tap_eff  = flush ? '0 : tap;
  assign prev_eff = flush ? '0 : prev_sum_q;
  assign x        = decode_sample(bus.in_sum, prev_eff, tap_eff);

  box_inverse_filter_sample_history #(
    .DEPTH (FILTER_SIZE),
    .WIDTH (SUM_WIDTH)
  ) u_sample_history (
    .clk    (clk),
    .clr_i  (rst || flush),
    .push_i (accept && !rst),
    .din_i  (x),
    .tap_o  (tap)
  );

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    prev_sum_d = prev_eff;
    if (accept) begin
      out_d      = x[WIDTH-1:0];
      out_vld_d  = 1'b1;
      prev_sum_d = bus.in_sum;
    end else if (out_vld_q && bus.out_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  // Stage boundary: output register and previous-sum register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      prev_sum_q <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      prev_sum_q <= prev_sum_d;
    end
  end

`ifdef BOX_INVERSE_CHECK_EN
  // Window-fill tracking only influences checking; decode is the same in
  // both states because the history is zero-filled.
  localparam int          CNT_W   = $clog2(FILTER_SIZE + 1);
  localparam logic [0:0]  ST_FILL = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;

  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d, cnt_base;
  logic [0:0]       state_q, state_d, state_eff;
  logic             err_q, err_d;

  always_comb begin
    cnt_base   = flush ? '0 : fill_cnt_q;
    state_eff  = flush ? ST_FILL : state_q;
    fill_cnt_d = cnt_base;
    state_d    = state_eff;
    err_d      = err_q;
    if (accept) begin
      if (cnt_base < CNT_W'(FILTER_SIZE)) fill_cnt_d = cnt_base + 1'b1;
      if (cnt_base == CNT_W'(FILTER_SIZE - 1)) state_d = ST_RUN;
      // Upper bits of a valid sample must be zero.
      if (x[SUM_WIDTH-1:WIDTH] != '0) err_d = 1'b1;
      // With unsigned samples the sum cannot drop while the window fills.
      if (state_eff == ST_FILL && bus.in_sum < prev_eff) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q <= '0;
      state_q    <= ST_FILL;
      err_q      <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      state_q    <= state_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_box_inverse_filter.sv
// tb_box_inverse_filter
//   Directed vector table, a few hand-written sequences and a randomized
//   stream decoded against the original samples fed through a golden
//   moving-sum producer.
module tb_box_inverse_filter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 34;

  logic clk = 1'b0;
  logic rst;
  logic flush;
`ifdef BOX_INVERSE_CHECK_EN
  logic err;
`endif

  box_inverse_filter_if #(.WIDTH(W), .SUM_WIDTH(SW)) bus ();

  box_inverse_filter #(
    .FILTER_SIZE (N),
    .WIDTH       (W),
    .SUM_WIDTH   (SW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef BOX_INVERSE_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    bit            iv;
    logic [SW-1:0] sum;
    bit            ordy;
    bit            fl;
    bit            erdy;
    bit            evld;
    logic [W-1:0]  eout;
  } vec_t;

  vec_t vec[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input string nm, input bit iv, input logic [SW-1:0] sum,
                     input bit ordy, input bit fl, input bit erdy,
                     input bit evld, input logic [W-1:0] eout);
    vec_t r;
    r.nm = nm; r.iv = iv; r.sum = sum; r.ordy = ordy; r.fl = fl;
    r.erdy = erdy; r.evld = evld; r.eout = eout;
    vec.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Golden producer: window sum of the last N samples ending at idx.
  int unsigned smp[];
  function automatic logic [SW-1:0] win_sum(input int idx);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) begin
      if (idx - k >= 0) s = s + SW'(smp[idx-k]);
    end
    return s;
  endfunction

  localparam logic [SW-1:0] F = 34'h0_FFFF_FFFF;

  initial begin
    int unsigned exp_q[$];
    int idx, cyc;
    int M;

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.out_ready = 1'b1;
    edge_wait();
    edge_wait();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out", bus.out, 0);
    chk("reset_in_ready", bus.in_ready, 1);
`ifdef BOX_INVERSE_CHECK_EN
    chk("reset_err", err, 0);
`endif
    rst = 1'b0;

    // constant samples of 10
    add("const0", 1, 10, 1, 0, 1, 1, 10);
    add("const1", 1, 20, 1, 0, 1, 1, 10);
    add("const2", 1, 30, 1, 0, 1, 1, 10);
    add("const3", 1, 40, 1, 0, 1, 1, 10);
    add("const4", 1, 40, 1, 0, 1, 1, 10);
    add("const5", 1, 40, 1, 0, 1, 1, 10);
    // flush together with accept, then continue the new window
    add("flush_acc",   1,  7, 1, 1, 1, 1, 7);
    add("after_flush", 1, 12, 1, 0, 1, 1, 5);
    add("flush_idle1", 0,  0, 1, 1, 1, 0, 5);
    // ramp 1..8 through a 4-window sum
    add("ramp1", 1,  1, 1, 0, 1, 1, 1);
    add("ramp2", 1,  3, 1, 0, 1, 1, 2);
    add("ramp3", 1,  6, 1, 0, 1, 1, 3);
    add("ramp4", 1, 10, 1, 0, 1, 1, 4);
    add("ramp5", 1, 14, 1, 0, 1, 1, 5);
    add("ramp6", 1, 18, 1, 0, 1, 1, 6);
    add("ramp7", 1, 22, 1, 0, 1, 1, 7);
    add("ramp8", 1, 26, 1, 0, 1, 1, 8);
    add("flush_idle2", 0, 0, 1, 1, 1, 0, 8);
    // backpressure: samples 10, 11, 12 with a 3-cycle stall
    add("bp_first",   1, 10, 1, 0, 1, 1, 10);
    add("bp_hold1",   1, 21, 0, 0, 0, 1, 10);
    add("bp_hold2",   1, 21, 0, 0, 0, 1, 10);
    add("bp_hold3",   1, 21, 0, 0, 0, 1, 10);
    add("bp_release", 1, 21, 1, 0, 1, 1, 11);
    add("bp_next",    1, 33, 1, 0, 1, 1, 12);
    // flush leaves a pending output untouched
    add("flush_hold",  0, 0, 0, 1, 0, 1, 12);
    add("flush_idle3", 0, 0, 1, 1, 1, 0, 12);
    // all-ones samples, then 0 and 5 (sum difference goes negative)
    add("ones1", 1, F,     1, 0, 1, 1, 32'hFFFF_FFFF);
    add("ones2", 1, 2*F,   1, 0, 1, 1, 32'hFFFF_FFFF);
    add("ones3", 1, 3*F,   1, 0, 1, 1, 32'hFFFF_FFFF);
    add("ones4", 1, 4*F,   1, 0, 1, 1, 32'hFFFF_FFFF);
    add("ones5", 1, 4*F,   1, 0, 1, 1, 32'hFFFF_FFFF);
    add("ones_zero", 1, 3*F, 1, 0, 1, 1, 0);
    add("ones_five", 1, 2*F + 5, 1, 0, 1, 1, 5);

    for (int i = 0; i < vec.size(); i++) begin
      bus.in_valid  = vec[i].iv;
      bus.in_sum    = vec[i].sum;
      bus.out_ready = vec[i].ordy;
      flush         = vec[i].fl;
      @(negedge clk);
      chk({vec[i].nm, "_in_ready"}, bus.in_ready, vec[i].erdy);
      edge_wait();
      chk({vec[i].nm, "_out_valid"}, bus.out_valid, vec[i].evld);
      chk({vec[i].nm, "_out"}, bus.out, vec[i].eout);
    end
    flush = 1'b0;
`ifdef BOX_INVERSE_CHECK_EN
    chk("table_err", err, 0);
`endif

    // reset mid-stream drops the pending output and clears history
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_sum = 34'h50; bus.out_ready = 1'b0;
    edge_wait();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out", bus.out, 0);
    rst = 1'b0; bus.in_sum = 9; bus.out_ready = 1'b1;
    edge_wait();
    chk("post_rst_out_valid", bus.out_valid, 1);
    chk("post_rst_out", bus.out, 9);

`ifdef BOX_INVERSE_CHECK_EN
    rst = 1'b1; bus.in_valid = 1'b0;
    edge_wait();
    rst = 1'b0; bus.in_valid = 1'b1; bus.in_sum = 20;
    edge_wait();
    chk("chk_first_err", err, 0);
    bus.in_sum = 15;
    edge_wait();
    chk("chk_drop_err", err, 1);
    bus.in_valid = 1'b0; flush = 1'b1;
    edge_wait();
    chk("chk_flush_err", err, 1);
    flush = 1'b0; rst = 1'b1;
    edge_wait();
    chk("chk_rst_err", err, 0);
    chk("chk_rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;
`endif

    // randomized stream against golden producer
    rst = 1'b1; bus.in_valid = 1'b0;
    edge_wait();
    rst = 1'b0;
    M = 400;
    smp = new[M];
    for (int i = 0; i < M; i++) begin
      case ($urandom_range(0, 7))
        0:       smp[i] = 32'hFFFF_FFFF;
        1:       smp[i] = 0;
        default: smp[i] = $urandom;
      endcase
    end
    idx = 0; cyc = 0;
    while ((idx < M || exp_q.size() > 0) && cyc < 5000) begin
      bus.in_valid  = (idx < M) && ($urandom_range(0, 9) < 7);
      bus.in_sum    = (idx < M) ? win_sum(idx) : '0;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      chk("rnd_in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_out", 1, 0);
        end else begin
          chk("rnd_out", bus.out, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(smp[idx]);
        idx++;
      end
      edge_wait();
      cyc++;
    end
    if (cyc >= 5000) chk("rnd_timeout", cyc, 0);
    bus.in_valid = 1'b0;
`ifdef BOX_INVERSE_CHECK_EN
    chk("rnd_err", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
